// File: rtl/fft_1d_4_in_buf.sv
// Serial-to-frame input buffer for the 4-point FFT core: packs 4 samples per frame into ping-pong banks.
// Optional FFT4_IN_BITREV_EN stores sample k in slot bitrev2(k) so the core sees DIT input order.
module fft_1d_4_in_buf #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_re,
    input  logic [DW-1:0] s_im,
    input  logic          s_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] in0_r,
    output logic [DW-1:0] in0_i,
    output logic [DW-1:0] in1_r,
    output logic [DW-1:0] in1_i,
    output logic [DW-1:0] in2_r,
    output logic [DW-1:0] in2_i,
    output logic [DW-1:0] in3_r,
    output logic [DW-1:0] in3_i,
    output logic          err_frame
);

    logic [DW-1:0] bank_re_reg [2][4];
    logic [DW-1:0] bank_im_reg [2][4];
    logic [1:0]    full_reg;
    logic [1:0]    full_next;
    logic          wr_bank_reg;
    logic          rd_bank_reg;
    logic [1:0]    wr_idx_reg;
    logic          err_frame_reg;
    logic [1:0]    wr_slot;
    logic          accept;
    logic          commit;
    logic          xfer;
    logic [DW-1:0] slot_re [4];
    logic [DW-1:0] slot_im [4];

`ifdef FFT4_IN_BITREV_EN
    assign wr_slot = {wr_idx_reg[0], wr_idx_reg[1]};
`else
    assign wr_slot = wr_idx_reg;
`endif

    assign s_ready = !full_reg[wr_bank_reg];
    assign m_valid = full_reg[rd_bank_reg];
    assign accept  = s_valid && s_ready;
    assign commit  = accept && (wr_idx_reg == 2'd3);
    assign xfer    = m_valid && m_ready;

    // Commit and release always target different banks, so both can apply in one cycle.
    always_comb begin
        full_next = full_reg;
        if (commit) full_next[wr_bank_reg] = 1'b1;
        if (xfer)   full_next[rd_bank_reg] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < 4; s++) begin
                    bank_re_reg[b][s] <= '0;
                    bank_im_reg[b][s] <= '0;
                end
            end
            full_reg      <= 2'b00;
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            wr_idx_reg    <= 2'd0;
            err_frame_reg <= 1'b0;
        end else begin
            full_reg      <= full_next;
            // Framing error: s_last anywhere but the 4th sample, or missing on the 4th.
            err_frame_reg <= accept && (s_last != (wr_idx_reg == 2'd3));
            if (accept) begin
                bank_re_reg[wr_bank_reg][wr_slot] <= s_re;
                bank_im_reg[wr_bank_reg][wr_slot] <= s_im;
                if (commit || s_last) wr_idx_reg <= 2'd0;
                else                  wr_idx_reg <= wr_idx_reg + 2'd1;
                if (commit) wr_bank_reg <= !wr_bank_reg;
            end
            if (xfer) rd_bank_reg <= !rd_bank_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign slot_re[gi] = bank_re_reg[rd_bank_reg][gi];
            assign slot_im[gi] = bank_im_reg[rd_bank_reg][gi];
        end
    endgenerate

    assign in0_r = slot_re[0];
    assign in0_i = slot_im[0];
    assign in1_r = slot_re[1];
    assign in1_i = slot_im[1];
    assign in2_r = slot_re[2];
    assign in2_i = slot_im[2];
    assign in3_r = slot_re[3];
    assign in3_i = slot_im[3];
    assign err_frame = err_frame_reg;

endmodule
